d_mem_arbiter: RTL

- Shares the single D_MEMORY_WRAPPER request/response port between two requesters: port 0 = CPU load/store unit, port 1 = debug/preload master (bench memory init, post-finish memory dump).
- One transaction is outstanding at a time.
- Arbitration is round-robin, and the requester handshakes are valid/ready.
- A response-timeout watchdog turns a hung memory into an error response plus a sticky flag.

---
 rtl/d_mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/d_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : d_mem_arbiter
// Purpose  : Shares one data-memory request/response port between two
//            requesters (port 0 = CPU load/store unit, port 1 = debug/preload
//            master). One transaction is in flight at a time, requesters are
//            served round-robin over valid/ready handshakes, and a watchdog
//            turns a memory that never answers into an error response plus a
//            sticky timeout flag.
// Ports    : clk, reset (async, active-low)
//            req_valid/req_ready/req_we/req_addr/req_wdata : requester side,
//                port i in bit i / slice [i*W +: W]
//            resp_valid/resp_rdata/resp_err : one-cycle response to the owner
//            mem_req_valid/mem_req_ready/mem_we/mem_addr/mem_wdata : memory
//                request channel
//            mem_resp_valid/mem_rdata : memory completion channel
//            grant_id, busy, timeout_flag : status
// Revision : 1.0 - initial release
// ============================================================================
module d_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    grant_id,
    output logic                    busy,
    output logic                    timeout_flag
);

    localparam logic [TO_WIDTH-1:0] C_TIMEOUT = TO_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [TO_WIDTH-1:0] C_CNT_ONE = TO_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_last_grant;
    logic                    r_grant_id;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_mem_req_valid;
    logic [TO_WIDTH-1:0]     r_cnt;
    logic [1:0]              r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_err;
    logic                    r_timeout_flag;

    logic                    w_winner;
    logic [1:0]              w_ready;
    logic                    w_accept;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    // Round-robin pick: a lone requester always wins; on a tie the port that
    // did not own the previous transaction wins.
    always_comb begin
        w_winner = 1'b0;
        if (req_valid == 2'b11) begin
            w_winner = ~r_last_grant;
        end else if (req_valid[1] && !req_valid[0]) begin
            w_winner = 1'b1;
        end
    end

    // Ready is offered only in IDLE and only to the winner, so at most one
    // request can ever be taken per cycle.
    always_comb begin
        w_ready = 2'b00;
        if ((r_state == S_IDLE) && (req_valid != 2'b00)) begin
            w_ready = w_winner ? 2'b10 : 2'b01;
        end
    end

    assign w_accept    = |(req_valid & w_ready);
    assign w_sel_we    = w_winner ? req_we[1] : req_we[0];
    assign w_sel_addr  = w_winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_last_grant    <= 1'b1;
            r_grant_id      <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_resp_valid    <= 2'b00;
            r_resp_rdata    <= '0;
            r_resp_err      <= 1'b0;
            r_timeout_flag  <= 1'b0;
        end else begin
            // Responses are single-cycle pulses; rdata/err keep their value.
            r_resp_valid <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we            <= w_sel_we;
                        r_addr          <= w_sel_addr;
                        r_wdata         <= w_sel_wdata;
                        r_grant_id      <= w_winner;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Backpressure here is unbounded; the watchdog only
                    // starts once memory has taken the request.
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    // A completion in the same cycle as the watchdog limit
                    // takes priority over the timeout.
                    if (mem_resp_valid) begin
                        r_resp_valid <= r_grant_id ? 2'b10 : 2'b01;
                        r_resp_rdata <= r_we ? '0 : mem_rdata;
                        r_resp_err   <= 1'b0;
                        r_last_grant <= r_grant_id;
                        r_state      <= S_IDLE;
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_resp_valid   <= r_grant_id ? 2'b10 : 2'b01;
                        r_resp_rdata   <= '0;
                        r_resp_err     <= 1'b1;
                        r_timeout_flag <= 1'b1;
                        r_last_grant   <= r_grant_id;
                        r_state        <= S_IDLE;
                    end else begin
                        // Stops at the limit, so it never wraps.
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = w_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_err      = r_resp_err;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign grant_id      = r_grant_id;
    assign busy          = (r_state != S_IDLE);
    assign timeout_flag  = r_timeout_flag;

endmodule
`default_nettype wire
